// File: rtl/fir_iq_pkg.sv
// rtl/fir_iq_pkg.sv - shared types, default half-coefficient table and requantiser for the I/Q FIR
package fir_iq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } fsm_t;

    typedef struct packed {
        logic               sat;
        logic signed [31:0] val;
    } sat_res_t;

    // Half table c0..c(NTAPS-1)/2 of the NTAPS=9 channel filter; longer filters pad with zeros.
    function automatic logic signed [7:0] def_half_coef(input int idx);
        case (idx)
            0:       def_half_coef = 8'shF5;
            1:       def_half_coef = 8'shE9;
            2:       def_half_coef = 8'sh1A;
            3:       def_half_coef = 8'sh4B;
            4:       def_half_coef = 8'sh69;
            default: def_half_coef = 8'sh00;
        endcase
    endfunction

    function automatic sat_res_t sat_round(input logic signed [63:0] acc,
                                           input int shift, input int out_w);
        logic signed [63:0] r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        sat_res_t           res;
        r   = (acc + (64'sd1 <<< (shift - 1))) >>> shift;
        hi  = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo  = -(64'sd1 <<< (out_w - 1));
        res.sat = 1'b0;
        res.val = r[31:0];
        if (r > hi) begin
            res.sat = 1'b1;
            res.val = hi[31:0];
        end else if (r < lo) begin
            res.sat = 1'b1;
            res.val = lo[31:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/fir_sym_chain.sv
// rtl/fir_sym_chain.sv - one channel: shared symmetric multipliers, transposed adder chain, requantiser
module fir_sym_chain
    import fir_iq_pkg::*;
#(
    parameter int IN_W      = 8,
    parameter int COEF_W    = 8,
    parameter int NTAPS     = 9,
    parameter int OUT_SHIFT = 11,
    parameter int OUT_W     = 4
) (
    input  logic                                   i_clk,
    input  logic                                   i_rst_n,
    input  logic                                   i_accept,
    input  logic                                   i_clear,
    input  logic [(NTAPS+1)/2-1:0][COEF_W-1:0]     i_coef,
    input  logic signed [IN_W-1:0]                 i_x,
    output logic signed [OUT_W-1:0]                o_y,
    output logic                                   o_sat
);

    localparam int ACC_W = IN_W + COEF_W + $clog2(NTAPS);
    localparam int NHALF = (NTAPS + 1) / 2;

    logic signed [ACC_W-1:0] w_x_ext;
    logic signed [ACC_W-1:0] w_prod [0:NHALF-1];
    logic signed [ACC_W-1:0] w_tap  [0:NTAPS-1];
    logic signed [ACC_W-1:0] w_acc;
    logic signed [ACC_W-1:0] r_p    [0:NTAPS-2];
    logic signed [OUT_W-1:0] r_y;
    sat_res_t                w_res;
    logic                    w_unused_val;

    assign w_x_ext = ACC_W'(i_x);

    for (genvar j = 0; j < NHALF; j++) begin : g_mul
        assign w_prod[j] = w_x_ext * ACC_W'($signed(i_coef[j]));
    end

    // Mirrored taps reuse the product of their partner instead of a second multiplier.
    for (genvar k = 0; k < NTAPS; k++) begin : g_tap
        if (k < NHALF) begin : g_lo
            assign w_tap[k] = w_prod[k];
        end else begin : g_hi
            assign w_tap[k] = w_prod[NTAPS-1-k];
        end
    end

    assign w_acc        = w_tap[0] + r_p[0];
    assign w_res        = sat_round(64'(w_acc), OUT_SHIFT, OUT_W);
    assign w_unused_val = ^w_res.val[31:OUT_W];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < NTAPS - 1; k++) r_p[k] <= '0;
            r_y <= '0;
        end else if (i_clear) begin
            for (int k = 0; k < NTAPS - 1; k++) r_p[k] <= '0;
        end else if (i_accept) begin
            for (int k = 0; k < NTAPS - 2; k++) r_p[k] <= w_tap[k+1] + r_p[k+1];
            r_p[NTAPS-2] <= w_tap[NTAPS-1];
            r_y          <= w_res.val[OUT_W-1:0];
        end
    end

    assign o_y   = r_y;
    assign o_sat = w_res.sat;

endmodule

// File: rtl/fir_iq_sym_filter.sv
// rtl/fir_iq_sym_filter.sv - symmetric I/Q channel FIR top: FSM, handshake, sticky overflow
// Optional FIR_COEF_LOAD_EN adds a runtime-writable half-coefficient register file.
module fir_iq_sym_filter
    import fir_iq_pkg::*;
#(
    parameter int IN_W      = 8,
    parameter int COEF_W    = 8,
    parameter int NTAPS     = 9,
    parameter int OUT_SHIFT = 11,
    parameter int OUT_W     = 4
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
`ifdef FIR_COEF_LOAD_EN
    input  logic                              i_coef_we,
    input  logic [$clog2((NTAPS+1)/2)-1:0]    i_coef_addr,
    input  logic [COEF_W-1:0]                 i_coef_data,
`endif
    input  logic                              i_sample_valid,
    input  logic signed [IN_W-1:0]            i_I_in,
    input  logic signed [IN_W-1:0]            i_Q_in,
    input  logic                              i_flush,
    input  logic                              i_ovf_clr,
    output logic signed [OUT_W-1:0]           o_I_out,
    output logic signed [OUT_W-1:0]           o_Q_out,
    output logic                              o_valid,
    output logic                              o_overflow,
    output logic                              o_busy
);

    localparam int NHALF = (NTAPS + 1) / 2;

    fsm_t                           r_state;
    fsm_t                           w_next;
    logic                           w_accept;
    logic                           w_clear;
    logic                           w_sat_i;
    logic                           w_sat_q;
    logic                           r_valid;
    logic                           r_overflow;
    logic [NHALF-1:0][COEF_W-1:0]   w_coef;

`ifdef FIR_COEF_LOAD_EN
    logic [NHALF-1:0][COEF_W-1:0]   r_coef;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int j = 0; j < NHALF; j++) r_coef[j] <= COEF_W'(def_half_coef(j));
        end else if (i_coef_we && r_state == IDLE && int'(i_coef_addr) < NHALF) begin
            r_coef[i_coef_addr] <= i_coef_data;
        end
    end

    assign w_coef = r_coef;
`else
    for (genvar j = 0; j < NHALF; j++) begin : g_coef
        assign w_coef[j] = COEF_W'(def_half_coef(j));
    end
`endif

    // Flush outranks a coincident sample; nothing is accepted while flushing.
    assign w_accept = i_sample_valid && !i_flush && (r_state != FLUSH);
    assign w_clear  = i_flush || (r_state == FLUSH);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (i_flush) w_next = FLUSH;
                     else if (i_sample_valid) w_next = RUN;
            RUN:     if (i_flush) w_next = FLUSH;
            FLUSH:   w_next = i_flush ? FLUSH : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_valid    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_valid    <= w_accept;
            r_overflow <= (w_accept && (w_sat_i || w_sat_q)) || (r_overflow && !i_ovf_clr);
        end
    end

    fir_sym_chain #(
        .IN_W(IN_W), .COEF_W(COEF_W), .NTAPS(NTAPS), .OUT_SHIFT(OUT_SHIFT), .OUT_W(OUT_W)
    ) u_chain_i (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_accept(w_accept), .i_clear(w_clear),
        .i_coef(w_coef), .i_x(i_I_in), .o_y(o_I_out), .o_sat(w_sat_i)
    );

    fir_sym_chain #(
        .IN_W(IN_W), .COEF_W(COEF_W), .NTAPS(NTAPS), .OUT_SHIFT(OUT_SHIFT), .OUT_W(OUT_W)
    ) u_chain_q (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_accept(w_accept), .i_clear(w_clear),
        .i_coef(w_coef), .i_x(i_Q_in), .o_y(o_Q_out), .o_sat(w_sat_q)
    );

    assign o_valid    = r_valid;
    assign o_overflow = r_overflow;
    assign o_busy     = (r_state == FLUSH);

endmodule
